adder_serial_rtl: RTL and testbench
===================================

# adder_serial_rtl

Multi-cycle, parametrised ripple adder/subtractor for the TinyRV1 datapath. It processes a `p_nbits`-wide operand pair `p_chunk` bits per cycle through one chunk-wide carry chain built from full-adder cells, with a carry register between cycles. It sits behind a val/rdy handshake so the control unit can stall on it. It trades latency for area against the single-cycle ripple adder and adds subtract mode and a signed-overflow flag.

## Interface
Parameters:
- `p_nbits`, 32, operand/result width; must be a multiple of `p_chunk`.
- `p_chunk`, 8, bits added per cycle; N = `p_nbits`/`p_chunk` compute cycles.

Ports:
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `in_val`  input  1  operands valid.
- `in_rdy`  output  1  block can accept operands.
- `in0`  input  `p_nbits`  operand A.
- `in1`  input  `p_nbits`  operand B.
- `cin`  input  1  carry-in; used only when `sub`=0.
- `sub`  input  1  0 = A+B+cin; 1 = A-B, computed as A+~B+1.
- `out_val`  output  1  result valid.
- `out_rdy`  input  1  consumer accepts result.
- `sum`  output  `p_nbits`  result.
- `cout`  output  1  carry out of the MSB. For subtract, 1 means no borrow.
- `ovf`  output  1  signed overflow: carry into the MSB XOR carry out of the MSB.

## Operation
The FSM has three states: IDLE, CALC, DONE.
- **IDLE:** `in_rdy`=1 and `out_val`=0.
  - If `in_val`=1 at the edge, latch `in0` into the A register.
  - Latch `sub ? ~in1 : in1` into the B register.
  - Load the carry register with `sub ? 1 : cin`.
  - Clear the chunk counter k to 0 and go to CALC.
- **CALC:** `in_rdy`=0 and `out_val`=0.
  - Each cycle, add chunk k (bits [k*p_chunk +: p_chunk]) of A and B plus the carry register through the chunk carry chain.
  - Write the chunk sum into the same slice of the result register, update the carry register, and increment k.
  - On the edge where k = N-1:
    - Capture carry-in-to-MSB XOR carry-out-of-MSB into `ovf`.
    - Capture the final carry into `cout`.
    - Go to DONE.
- **DONE:** `out_val`=1 and `in_rdy`=0.
  - `sum`, `cout` and `ovf` hold steady.
  - On an edge with `out_rdy`=1, go to IDLE.
  - `in_val` is ignored while not in IDLE.
- **Outputs:** `sum`, `cout` and `ovf` are driven directly from registers. Outside DONE their values are don't-care for the consumer, but they must not contain X after reset.
- **Width rules:**
  - All arithmetic is modulo 2^`p_nbits`.
  - `cout` is bit `p_nbits` of the true sum.
  - `p_chunk` = `p_nbits` degenerates to one CALC cycle.
  - `p_chunk` = 1 is fully bit-serial.
- **Reset:**
  - `rst`=1 at an edge forces IDLE and clears the result register, `cout`, `ovf`, the carry register and k to 0.
  - Reset wins over every handshake in the same cycle.
  - Reset during CALC or DONE discards the operation; no `out_val` pulse follows.

## Timing
- **Accept edge:** call the accept edge (IDLE, `in_val`=1) edge 0.
- **Compute:** CALC occupies the cycles after edges 0 through N-1.
- **Result:** `out_val` rises in the cycle after edge N. For the defaults (N=4), `out_val` is first high 4 cycles after the accept cycle.
- **Latency:** the minimum from the accept edge to the first `out_val`-high cycle is N edges.
- **Throughput:**
  - The result handshake edge returns the FSM to IDLE.
  - The earliest next accept is the edge after that.
  - Best case is one operation per N+2 cycles.
- **Back-pressure:**
  - `out_rdy`=0 holds DONE indefinitely, with all outputs stable.
  - `out_rdy` is sampled only in DONE; it is don't-care elsewhere.
- **Input stability:** operands need to be stable only in the accept cycle. Changes to `in0`, `in1`, `cin` or `sub` after edge 0 have no effect.
- **Post-reset state:** in the first cycle after a reset edge, `in_rdy`=1, `out_val`=0, `sum`=0, `cout`=0, `ovf`=0.

## Test plan
- **Reset:** hold `rst` for 2 cycles, then release -> `in_rdy`=1, `out_val`=0, `sum`=0, `cout`=0, `ovf`=0. Asserting `in_val` during reset is ignored.
- **Add with carry-out (32/8):** `in0`=0xFFFFFFFF, `in1`=0x00000001, `cin`=0, `sub`=0 -> `out_val` high 4 cycles after accept, `sum`=0x00000000, `cout`=1, `ovf`=0.
- **Subtract and signed overflow (32/8):**
  - 5-7 -> `sum`=0xFFFFFFFE, `cout`=0, `ovf`=0.
  - 0x7FFFFFFF+0x00000001 -> `sum`=0x80000000, `cout`=0, `ovf`=1.
  - 0x80000000-1 -> `sum`=0x7FFFFFFF, `cout`=1, `ovf`=1.
- **Back-pressure (32/8):** result ready with `out_rdy`=0 for 3 cycles while `in_val`=1 -> outputs stable, `in_rdy`=0, no new accept. Raise `out_rdy` -> IDLE next cycle, and the next accept occurs exactly one cycle later.
- **Reset mid-operation (32/8):** assert `rst` in the second CALC cycle -> `in_rdy`=1 the following cycle, no `out_val` pulse. A subsequent operation 3+4 returns `sum`=7.
- **Parameter sweep:** random constrained-sign operands, compared against a reference model in the bench, covering:
  - `p_nbits`=8, `p_chunk`=1 -> 8-cycle latency.
  - `p_nbits`=8, `p_chunk`=8 -> 1-cycle latency.
  - `cin`=1 with 0x7F+0x00 -> `sum`=0x80, `ovf`=1.

Source files
------------

// File: rtl/adder_serial_rtl.sv
// adder_serial_rtl
//   Multi-cycle chunked ripple adder/subtractor behind a val/rdy handshake.
//   Adds p_nbits-wide operands p_chunk bits per cycle through a single
//   chunk-wide full-adder carry chain, keeping the inter-chunk carry in a
//   register. Subtract is performed as A + ~B + 1.
//
// Parameters
//   p_nbits  operand/result width (multiple of p_chunk)
//   p_chunk  bits processed per cycle; N = p_nbits/p_chunk compute cycles
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   in_val   operands valid          in_rdy   block can accept operands
//   in0      operand A               in1      operand B
//   cin      carry-in (add only)     sub      1 = A-B, 0 = A+B+cin
//   out_val  result valid            out_rdy  consumer accepts result
//   sum      result                  cout     carry out of MSB (1 = no borrow)
//   ovf      signed overflow
module adder_serial_rtl #(
  parameter int p_nbits = 32,
  parameter int p_chunk = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_val,
  output logic               in_rdy,
  input  logic [p_nbits-1:0] in0,
  input  logic [p_nbits-1:0] in1,
  input  logic               cin,
  input  logic               sub,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [p_nbits-1:0] sum,
  output logic               cout,
  output logic               ovf
);

  localparam int N  = p_nbits / p_chunk;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [p_nbits-1:0] a_reg;
  logic [p_nbits-1:0] b_reg;
  logic [p_nbits-1:0] sum_reg;
  logic               carry_reg;
  logic               cout_reg;
  logic               ovf_reg;
  logic [KW-1:0]      k;

  logic [p_chunk-1:0] a_chunk;
  logic [p_chunk-1:0] b_chunk;
  logic [p_chunk-1:0] s_chunk;
  logic [p_chunk:0]   c;
  logic               last;

  assign last = (k == KW'(N - 1));

  // Chunk carry chain: c[i] is the carry into bit i of the current chunk,
  // so c[p_chunk-1] is the carry into the MSB on the final chunk.
  always_comb begin
    a_chunk = a_reg[k*p_chunk +: p_chunk];
    b_chunk = b_reg[k*p_chunk +: p_chunk];
    s_chunk = '0;
    c       = '0;
    c[0]    = carry_reg;
    for (int unsigned i = 0; i < p_chunk; i++) begin
      s_chunk[i] = a_chunk[i] ^ b_chunk[i] ^ c[i];
      c[i+1]     = (a_chunk[i] & b_chunk[i]) | (c[i] & (a_chunk[i] ^ b_chunk[i]));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_rdy     = 1'b0;
    out_val    = 1'b0;
    case (state)
      IDLE: begin
        in_rdy = 1'b1;
        if (in_val) state_next = CALC;
      end
      CALC: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        out_val = 1'b1;
        if (out_rdy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      k         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_val) begin
            a_reg     <= in0;
            b_reg     <= sub ? ~in1 : in1;
            carry_reg <= sub ? 1'b1 : cin;
            k         <= '0;
          end
        end
        CALC: begin
          sum_reg[k*p_chunk +: p_chunk] <= s_chunk;
          carry_reg                     <= c[p_chunk];
          if (last) begin
            cout_reg <= c[p_chunk];
            ovf_reg  <= c[p_chunk-1] ^ c[p_chunk];
          end else begin
            k <= k + KW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_adder_serial_rtl.sv
// Self-checking bench for adder_serial_rtl: three instances (32/8, 8/1, 8/8)
// share operand buses; a select picks which one is driven and observed.
module tb_adder_serial_rtl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [1:0]  sel = 2'd0;
  logic        in_val_drv = 1'b0;
  logic        out_rdy_drv = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        op_cin = 1'b0;
  logic        op_sub = 1'b0;

  logic        in_val0, in_val1, in_val2;
  logic        out_rdy0, out_rdy1, out_rdy2;
  logic        in_rdy0, in_rdy1, in_rdy2;
  logic        out_val0, out_val1, out_val2;
  logic [31:0] sum0;
  logic [7:0]  sum1, sum2;
  logic        cout0, cout1, cout2;
  logic        ovf0, ovf1, ovf2;

  assign in_val0  = in_val_drv  & (sel == 2'd0);
  assign in_val1  = in_val_drv  & (sel == 2'd1);
  assign in_val2  = in_val_drv  & (sel == 2'd2);
  assign out_rdy0 = out_rdy_drv & (sel == 2'd0);
  assign out_rdy1 = out_rdy_drv & (sel == 2'd1);
  assign out_rdy2 = out_rdy_drv & (sel == 2'd2);

  adder_serial_rtl #(.p_nbits(32), .p_chunk(8)) dut0 (
    .clk(clk), .rst(rst), .in_val(in_val0), .in_rdy(in_rdy0),
    .in0(op_a), .in1(op_b), .cin(op_cin), .sub(op_sub),
    .out_val(out_val0), .out_rdy(out_rdy0), .sum(sum0), .cout(cout0), .ovf(ovf0)
  );

  adder_serial_rtl #(.p_nbits(8), .p_chunk(1)) dut1 (
    .clk(clk), .rst(rst), .in_val(in_val1), .in_rdy(in_rdy1),
    .in0(op_a[7:0]), .in1(op_b[7:0]), .cin(op_cin), .sub(op_sub),
    .out_val(out_val1), .out_rdy(out_rdy1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  adder_serial_rtl #(.p_nbits(8), .p_chunk(8)) dut2 (
    .clk(clk), .rst(rst), .in_val(in_val2), .in_rdy(in_rdy2),
    .in0(op_a[7:0]), .in1(op_b[7:0]), .cin(op_cin), .sub(op_sub),
    .out_val(out_val2), .out_rdy(out_rdy2), .sum(sum2), .cout(cout2), .ovf(ovf2)
  );

  logic        in_rdy_m, out_val_m, cout_m, ovf_m;
  logic [31:0] sum_m;
  always_comb begin
    in_rdy_m  = in_rdy0;
    out_val_m = out_val0;
    sum_m     = sum0;
    cout_m    = cout0;
    ovf_m     = ovf0;
    case (sel)
      2'd1: begin
        in_rdy_m = in_rdy1; out_val_m = out_val1; sum_m = {24'd0, sum1};
        cout_m = cout1; ovf_m = ovf1;
      end
      2'd2: begin
        in_rdy_m = in_rdy2; out_val_m = out_val2; sum_m = {24'd0, sum2};
        cout_m = cout2; ovf_m = ovf2;
      end
      default: ;
    endcase
  end

  int          total = 0;
  int          bad = 0;
  int unsigned cur_w = 32;
  int          cur_n = 4;
  logic [31:0] exp_sum;
  logic        exp_cout, exp_ovf;

  // Reference: true sum of A + B' + c at width w, B' = ~B and c = 1 for subtract.
  // Signed overflow is read off the operand and result signs.
  function automatic logic [33:0] ref_add(input int unsigned w, input logic [31:0] a,
                                          input logic [31:0] b, input logic c, input logic s);
    logic [63:0] mask, aa, bb, t;
    logic        sa, sb, sr, co, ov;
    mask = (64'd1 << w) - 64'd1;
    aa   = {32'd0, a} & mask;
    bb   = (s ? ~{32'd0, b} : {32'd0, b}) & mask;
    t    = aa + bb + {63'd0, (s ? 1'b1 : c)};
    sa   = aa[w-1];
    sb   = bb[w-1];
    sr   = t[w-1];
    co   = t[w];
    ov   = (sa == sb) && (sr != sa);
    return {ov, co, t[31:0] & mask[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    assert (got === expv) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, expv);
    end
  endtask

  task automatic pick(input logic [1:0] s);
    sel = s;
    cur_w = (s == 2'd0) ? 32 : 8;
    cur_n = (s == 2'd0) ? 4 : (s == 2'd1) ? 8 : 1;
  endtask

  task automatic scramble();
    op_a   = $urandom;
    op_b   = $urandom;
    op_cin = 1'($urandom);
    op_sub = 1'($urandom);
  endtask

  task automatic set_exp(input logic [31:0] a, input logic [31:0] b, input logic c, input logic s);
    logic [33:0] r;
    r = ref_add(cur_w, a, b, c, s);
    exp_sum  = r[31:0];
    exp_cout = r[32];
    exp_ovf  = r[33];
  endtask

  task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic c, input logic s);
    op_a = a; op_b = b; op_cin = c; op_sub = s;
    in_val_drv = 1'b1;
    chk("acc_rdy", {31'd0, in_rdy_m}, 32'd1);
    set_exp(a, b, c, s);
    @(posedge clk); #1;
    in_val_drv = 1'b0;
    scramble();
    chk("acc_taken", {31'd0, in_rdy_m}, 32'd0);
  endtask

  // Called one time unit after the accept edge.
  task automatic wait_result(input string tag);
    int cnt = 0;
    while (out_val_m !== 1'b1 && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk({tag, "_lat"}, 32'(cnt), 32'(cur_n));
    chk({tag, "_sum"}, sum_m, exp_sum);
    chk({tag, "_cout"}, {31'd0, cout_m}, {31'd0, exp_cout});
    chk({tag, "_ovf"}, {31'd0, ovf_m}, {31'd0, exp_ovf});
  endtask

  task automatic release_result(input string tag);
    out_rdy_drv = 1'b1;
    @(posedge clk); #1;
    out_rdy_drv = 1'b0;
    chk({tag, "_idle_rdy"}, {31'd0, in_rdy_m}, 32'd1);
    chk({tag, "_idle_val"}, {31'd0, out_val_m}, 32'd0);
  endtask

  task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic c, input logic s,
                          input logic [31:0] es, input logic ec, input logic eo);
    accept(a, b, c, s);
    exp_sum = es; exp_cout = ec; exp_ovf = eo;
    wait_result(tag);
    release_result(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    logic [31:0] na, nb;

    // Reset with in_val asserted
    pick(2'd0);
    rst = 1'b1;
    in_val_drv = 1'b1;
    op_a = 32'h1234_5678; op_b = 32'h1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_rdy", {31'd0, in_rdy_m}, 32'd1);
    chk("rst_out_val", {31'd0, out_val_m}, 32'd0);
    chk("rst_sum", sum_m, 32'd0);
    chk("rst_cout", {31'd0, cout_m}, 32'd0);
    chk("rst_ovf", {31'd0, ovf_m}, 32'd0);
    rst = 1'b0;
    in_val_drv = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_idle", {31'd0, in_rdy_m}, 32'd1);

    // Directed 32/8 cases
    directed("add_carry", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    directed("sub_5_7",   32'd5,         32'd7,         1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    directed("ovf_pos",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    directed("ovf_neg",   32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

    // Back-pressure: hold DONE for 3 cycles with a pending in_val
    accept(32'h0123_4567, 32'h89AB_CDEF, 1'b1, 1'b0);
    wait_result("bp");
    na = 32'h0000_1000; nb = 32'h0000_0234;
    op_a = na; op_b = nb; op_cin = 1'b0; op_sub = 1'b1;
    in_val_drv = 1'b1;
    out_rdy_drv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_val", {31'd0, out_val_m}, 32'd1);
      chk("bp_rdy", {31'd0, in_rdy_m}, 32'd0);
      chk("bp_sum", sum_m, exp_sum);
      chk("bp_cout", {31'd0, cout_m}, {31'd0, exp_cout});
      chk("bp_ovf", {31'd0, ovf_m}, {31'd0, exp_ovf});
    end
    out_rdy_drv = 1'b1;
    @(posedge clk); #1;
    out_rdy_drv = 1'b0;
    chk("bp_idle_rdy", {31'd0, in_rdy_m}, 32'd1);
    chk("bp_idle_val", {31'd0, out_val_m}, 32'd0);
    set_exp(na, nb, 1'b0, 1'b1);
    @(posedge clk); #1;
    in_val_drv = 1'b0;
    scramble();
    chk("bp_next_acc", {31'd0, in_rdy_m}, 32'd0);
    wait_result("bp_next");
    chk("bp_next_const", exp_sum, 32'h0000_0DCC);
    release_result("bp_next");

    // Reset during the second CALC cycle
    accept(32'hDEAD_BEEF, 32'h1111_1111, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_rdy", {31'd0, in_rdy_m}, 32'd1);
    chk("mid_rst_val", {31'd0, out_val_m}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("mid_rst_no_val", {31'd0, out_val_m}, 32'd0);
    end
    directed("after_rst", 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0);

    // 8-bit configurations: carry-in into signed overflow
    pick(2'd1);
    directed("b1_cin", 32'h7F, 32'h00, 1'b1, 1'b0, 32'h80, 1'b0, 1'b1);
    pick(2'd2);
    directed("b8_cin", 32'h7F, 32'h00, 1'b1, 1'b0, 32'h80, 1'b0, 1'b1);

    // Random sweep over all three configurations with sign-pattern control
    for (int s = 0; s < 3; s++) begin
      pick(2'(s));
      for (int i = 0; i < 12; i++) begin
        a = $urandom;
        b = $urandom;
        a[cur_w-1] = i[0];
        b[cur_w-1] = i[1];
        if (cur_w < 32) begin
          a = a & ((32'd1 << cur_w) - 32'd1);
          b = b & ((32'd1 << cur_w) - 32'd1);
        end
        accept(a, b, 1'($urandom), 1'($urandom));
        wait_result("rand");
        release_result("rand");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
